// File: rtl/tap_bsr_controller_if.sv
// Boundary-cell wrapper and core scan chain bundle driven by the TAP controller.
// master: controller side (drives the chain controls and serial inputs).
// slave : wrapper/core side (returns the chain serial outputs).
//   bsr_tdi        serial input to the head of the boundary chain
//   bsr_tdo        serial output from the tail of the boundary chain
//   bsr_ce         boundary-chain clock enable
//   Shift_or_Load  1 = shift, 0 = capture/load
//   Update         one-cycle update strobe
//   Test_or_Normal 1 = boundary cells drive captured/updated value
//   scan_en        core scan enable
//   scan_in        core scan input
//   scan_out       core scan output
interface tap_bsr_controller_if;
  logic bsr_tdi;
  logic bsr_tdo;
  logic bsr_ce;
  logic Shift_or_Load;
  logic Update;
  logic Test_or_Normal;
  logic scan_en;
  logic scan_in;
  logic scan_out;

  modport master (
    output bsr_tdi, bsr_ce, Shift_or_Load, Update, Test_or_Normal,
           scan_en, scan_in,
    input  bsr_tdo, scan_out
  );

  modport slave (
    input  bsr_tdi, bsr_ce, Shift_or_Load, Update, Test_or_Normal,
           scan_en, scan_in,
    output bsr_tdo, scan_out
  );
endinterface

// File: rtl/tap_bsr_controller.sv
// Single-clock 1149.1-style TAP controller sequencing the s9234 boundary-scan
// chain and core scan chain.
// Optional feature macro: TAP_IDCODE_EN (adds 32-bit ID register, opcode 100
// becomes IDCODE and is the reset instruction).
// Ports:
//   CK      system clock, rising edge
//   RST     synchronous active-high reset
//   TMS/TDI test mode select / test data in
//   TDO     combinational serial output of the selected register
//   TDO_EN  high in Shift-IR and Shift-DR
//   chain   boundary/scan chain bundle (master side)
module tap_bsr_controller #(
  parameter int unsigned IR_W       = 3,
  parameter int unsigned BSR_LEN    = 75,
  parameter logic [31:0] IDCODE_VAL = 32'h0923_4001
) (
  input  logic                 CK,
  input  logic                 RST,
  input  logic                 TMS,
  input  logic                 TDI,
  output logic                 TDO,
  output logic                 TDO_EN,
  tap_bsr_controller_if.master chain
);

  typedef enum logic [3:0] {
    S_TLR, S_RTI,
    S_SEL_DR, S_CAP_DR, S_SH_DR, S_EX1_DR, S_PAUSE_DR, S_EX2_DR, S_UPD_DR,
    S_SEL_IR, S_CAP_IR, S_SH_IR, S_EX1_IR, S_PAUSE_IR, S_EX2_IR, S_UPD_IR
  } tap_state_e;

  localparam logic [IR_W-1:0] OP_EXTEST  = IR_W'(0);
  localparam logic [IR_W-1:0] OP_SAMPLE  = IR_W'(1);
  localparam logic [IR_W-1:0] OP_INTEST  = IR_W'(2);
  localparam logic [IR_W-1:0] OP_INTSCAN = IR_W'(3);
  localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(1);
`ifdef TAP_IDCODE_EN
  localparam logic [IR_W-1:0] OP_IDCODE  = IR_W'(4);
  localparam logic [IR_W-1:0] IR_RESET   = OP_IDCODE;
`else
  localparam logic [IR_W-1:0] IR_RESET   = {IR_W{1'b1}};
`endif

  tap_state_e      r_state;
  tap_state_e      w_next_state;
  logic [IR_W-1:0] r_ir_sr;
  logic [IR_W-1:0] r_ir_active;
  logic            r_bypass;
  logic            w_sel_bsr;
  logic            w_sel_scan;
  logic            w_sel_byp;
  logic            w_dr_tdo;
  logic            w_tap_reset;
  logic            w_unused_cfg;
`ifdef TAP_IDCODE_EN
  logic [31:0]     r_idcode;
  logic            w_sel_id;
`endif

  // BSR_LEN is documentation-only; keep it referenced.
  assign w_unused_cfg = ^{BSR_LEN[0], IDCODE_VAL[0]};

  // DR selection decoded from the active instruction
  always_comb begin
    w_sel_bsr  = (r_ir_active == OP_EXTEST) || (r_ir_active == OP_SAMPLE) ||
                 (r_ir_active == OP_INTEST);
    w_sel_scan = (r_ir_active == OP_INTSCAN);
`ifdef TAP_IDCODE_EN
    w_sel_id   = (r_ir_active == OP_IDCODE);
    w_sel_byp  = !(w_sel_bsr || w_sel_scan || w_sel_id);
`else
    w_sel_byp  = !(w_sel_bsr || w_sel_scan);
`endif
  end

  // State register
  always_ff @(posedge CK) begin
    if (RST) r_state <= S_TLR;
    else     r_state <= w_next_state;
  end

  // Next-state logic: standard 16-state TAP graph
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_TLR:      w_next_state = TMS ? S_TLR      : S_RTI;
      S_RTI:      w_next_state = TMS ? S_SEL_DR   : S_RTI;
      S_SEL_DR:   w_next_state = TMS ? S_SEL_IR   : S_CAP_DR;
      S_CAP_DR:   w_next_state = TMS ? S_EX1_DR   : S_SH_DR;
      S_SH_DR:    w_next_state = TMS ? S_EX1_DR   : S_SH_DR;
      S_EX1_DR:   w_next_state = TMS ? S_UPD_DR   : S_PAUSE_DR;
      S_PAUSE_DR: w_next_state = TMS ? S_EX2_DR   : S_PAUSE_DR;
      S_EX2_DR:   w_next_state = TMS ? S_UPD_DR   : S_SH_DR;
      S_UPD_DR:   w_next_state = TMS ? S_SEL_DR   : S_RTI;
      S_SEL_IR:   w_next_state = TMS ? S_TLR      : S_CAP_IR;
      S_CAP_IR:   w_next_state = TMS ? S_EX1_IR   : S_SH_IR;
      S_SH_IR:    w_next_state = TMS ? S_EX1_IR   : S_SH_IR;
      S_EX1_IR:   w_next_state = TMS ? S_UPD_IR   : S_PAUSE_IR;
      S_PAUSE_IR: w_next_state = TMS ? S_EX2_IR   : S_PAUSE_IR;
      S_EX2_IR:   w_next_state = TMS ? S_UPD_IR   : S_SH_IR;
      S_UPD_IR:   w_next_state = TMS ? S_SEL_DR   : S_RTI;
      default:    w_next_state = S_TLR;
    endcase
  end

  // Entering TEST_LOGIC_RESET through TMS has the same effect as RST.
  assign w_tap_reset = RST || (w_next_state == S_TLR);

  // Instruction and data registers
  always_ff @(posedge CK) begin
    if (w_tap_reset) begin
      r_ir_active <= IR_RESET;
      r_ir_sr     <= IR_CAPTURE;
      r_bypass    <= 1'b0;
`ifdef TAP_IDCODE_EN
      r_idcode    <= IDCODE_VAL;
`endif
    end else begin
      case (r_state)
        S_CAP_IR: r_ir_sr     <= IR_CAPTURE;
        S_SH_IR:  r_ir_sr     <= {TDI, r_ir_sr[IR_W-1:1]};
        S_UPD_IR: r_ir_active <= r_ir_sr;
        S_CAP_DR: begin
          if (w_sel_byp) r_bypass <= 1'b0;
`ifdef TAP_IDCODE_EN
          if (w_sel_id)  r_idcode <= IDCODE_VAL;
`endif
        end
        S_SH_DR: begin
          if (w_sel_byp) r_bypass <= TDI;
`ifdef TAP_IDCODE_EN
          if (w_sel_id)  r_idcode <= {TDI, r_idcode[31:1]};
`endif
        end
        default: ;
      endcase
    end
  end

  // Serial output of the selected data register
  always_comb begin
    w_dr_tdo = r_bypass;
    if (w_sel_bsr)       w_dr_tdo = chain.bsr_tdo;
    else if (w_sel_scan) w_dr_tdo = chain.scan_out;
`ifdef TAP_IDCODE_EN
    else if (w_sel_id)   w_dr_tdo = r_idcode[0];
`endif
  end

  // Output decode from the registered state
  always_comb begin
    TDO_EN               = 1'b0;
    TDO                  = w_dr_tdo;
    chain.bsr_tdi        = TDI;
    chain.scan_in        = TDI;
    chain.bsr_ce         = 1'b0;
    chain.Shift_or_Load  = 1'b1;
    chain.Update         = 1'b0;
    chain.scan_en        = 1'b0;
    chain.Test_or_Normal = (r_ir_active == OP_EXTEST) || (r_ir_active == OP_INTEST);
    case (r_state)
      S_SH_IR: begin
        TDO_EN = 1'b1;
        TDO    = r_ir_sr[0];
      end
      S_CAP_DR: begin
        chain.bsr_ce        = w_sel_bsr;
        chain.Shift_or_Load = !w_sel_bsr;
      end
      S_SH_DR: begin
        TDO_EN        = 1'b1;
        chain.bsr_ce  = w_sel_bsr;
        chain.scan_en = w_sel_scan;
      end
      S_UPD_DR: chain.Update = w_sel_bsr;
      default: ;
    endcase
  end

endmodule
